// File: rtl/parking_exit_gate.sv
// Exit-side car park controller: validates exit payment, runs the barrier and
// keeps lot occupancy from entry pulses and verified exits.
module parking_exit_gate #(
  parameter logic [3:0]  FEE_CODE    = 4'b1010,
  parameter int unsigned CAPACITY    = 16,
  parameter int unsigned CNT_W       = 5,
  parameter int unsigned PAY_TIMEOUT = 8,
  parameter int unsigned OPEN_CYCLES = 12,
  parameter int unsigned MAX_TRIES   = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             car_entered,
  input  logic             sensor_exit_approach,
  input  logic             sensor_exit_clear,
  input  logic [3:0]       pay_code,
  input  logic             pay_valid,
  input  logic             attendant_clr,
  output logic             gate_open,
  output logic             GREEN_LED,
  output logic             RED_LED,
  output logic [6:0]       HEX_1,
  output logic [6:0]       HEX_2,
  output logic [CNT_W-1:0] occupancy,
  output logic             lot_full,
  output logic             lot_empty,
  output logic             error
);

  localparam int unsigned WaitW = (PAY_TIMEOUT > 1) ? $clog2(PAY_TIMEOUT) : 1;
  localparam int unsigned OpenW = (OPEN_CYCLES > 1) ? $clog2(OPEN_CYCLES) : 1;
  localparam int unsigned TryW  = $clog2(MAX_TRIES + 1);

  localparam logic [CNT_W-1:0] OccMax   = CNT_W'(CAPACITY);
  localparam logic [WaitW-1:0] WaitLast = WaitW'(PAY_TIMEOUT - 1);
  localparam logic [OpenW-1:0] OpenLast = OpenW'(OPEN_CYCLES - 1);
  localparam logic [TryW-1:0]  TryMax   = TryW'(MAX_TRIES);

  // Segment patterns, a..g from MSB to LSB.
  localparam logic [6:0] SegOff = 7'b0000000;
  localparam logic [6:0] SegP   = 7'b1100111;
  localparam logic [6:0] SegA   = 7'b1110111;
  localparam logic [6:0] SegE   = 7'b1001111;
  localparam logic [6:0] SegR   = 7'b0000101;
  localparam logic [6:0] SegG   = 7'b1011110;
  localparam logic [6:0] SegO   = 7'b0011101;
  localparam logic [6:0] SegC   = 7'b1001110;
  localparam logic [6:0] SegL   = 7'b0001110;

  typedef enum logic [2:0] {
    StIdle,
    StWaitPay,
    StPayErr,
    StOpen,
    StClosing,
    StLock
  } state_e;

  state_e           state_q, state_d;
  logic [WaitW-1:0] wait_q, wait_d;
  logic [OpenW-1:0] open_q, open_d;
  logic [TryW-1:0]  tries_q, tries_d;
  logic [CNT_W-1:0] occ_q, occ_d;
  logic             approach_q;

  logic             code_ok, code_bad, empty_now;
  logic             fsm_err, occ_err, exit_dec;

  logic             gate_q, gate_d;
  logic             green_q, green_d;
  logic             red_q, red_d;
  logic             err_q, err_d;
  logic             full_q, full_d;
  logic             empty_q, empty_d;
  logic [6:0]       hex1_q, hex1_d;
  logic [6:0]       hex2_q, hex2_d;

  assign code_ok   = pay_valid && (pay_code == FEE_CODE);
  assign code_bad  = pay_valid && (pay_code != FEE_CODE);
  assign empty_now = (occ_q == '0);

  // State and counter registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      wait_q     <= '0;
      open_q     <= '0;
      tries_q    <= '0;
      occ_q      <= '0;
      approach_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_q     <= wait_d;
      open_q     <= open_d;
      tries_q    <= tries_d;
      occ_q      <= occ_d;
      approach_q <= sensor_exit_approach;
    end
  end

  // Next-state, counters, occupancy and error detection.
  always_comb begin
    state_d  = state_q;
    tries_d  = tries_q;
    fsm_err  = 1'b0;
    exit_dec = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (sensor_exit_approach) begin
          if (empty_now) begin
            fsm_err = !approach_q;
          end else begin
            state_d = StWaitPay;
          end
        end
      end
      StWaitPay: begin
        if (!sensor_exit_approach) begin
          state_d = StIdle;
        end else if (code_ok) begin
          state_d = StOpen;
        end else if (code_bad) begin
          state_d = StPayErr;
          tries_d = tries_q + TryW'(1);
          fsm_err = 1'b1;
        end else if (wait_q == WaitLast) begin
          state_d = StPayErr;
          fsm_err = 1'b1;
        end
      end
      StPayErr: begin
        if (code_ok) begin
          state_d = StOpen;
        end else if (code_bad) begin
          tries_d = tries_q + TryW'(1);
          fsm_err = 1'b1;
          if (tries_d >= TryMax) begin
            state_d = StLock;
          end
        end else if (!sensor_exit_approach) begin
          state_d = StIdle;
        end
      end
      StOpen: begin
        if (sensor_exit_clear) begin
          state_d  = StClosing;
          exit_dec = 1'b1;
        end else if (open_q == OpenLast) begin
          state_d = StIdle;
        end
      end
      StClosing: begin
        if (!sensor_exit_clear) begin
          state_d = StIdle;
        end
      end
      StLock: begin
        if (attendant_clr) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    if (state_d == StIdle || state_d == StOpen) begin
      tries_d = '0;
    end

    wait_d = (state_q == StWaitPay && state_d == StWaitPay) ? wait_q + WaitW'(1) : '0;
    open_d = (state_q == StOpen && state_d == StOpen) ? open_q + OpenW'(1) : '0;

    // An entry and an exit in the same cycle cancel out.
    occ_d   = occ_q;
    occ_err = 1'b0;
    if (car_entered && !exit_dec) begin
      if (occ_q == OccMax) begin
        occ_err = 1'b1;
      end else begin
        occ_d = occ_q + CNT_W'(1);
      end
    end else if (exit_dec && !car_entered) begin
      occ_d = occ_q - CNT_W'(1);
    end
  end

  // Registered outputs are decoded from the next state.
  always_comb begin
    gate_d  = 1'b0;
    green_d = 1'b0;
    red_d   = 1'b0;
    hex1_d  = SegOff;
    hex2_d  = SegOff;

    unique case (state_d)
      StWaitPay: begin
        hex1_d = SegP;
        hex2_d = SegA;
        red_d  = 1'b1;
      end
      StPayErr: begin
        hex1_d = SegE;
        hex2_d = SegR;
        red_d  = (state_q == StPayErr) ? !red_q : 1'b1;
      end
      StOpen: begin
        hex1_d  = SegG;
        hex2_d  = SegO;
        gate_d  = 1'b1;
        green_d = (state_q == StOpen) ? !green_q : 1'b1;
      end
      StClosing: begin
        hex1_d  = SegC;
        hex2_d  = SegL;
        green_d = 1'b1;
      end
      StLock: begin
        hex1_d = SegE;
        hex2_d = SegE;
        red_d  = 1'b1;
      end
      default: begin
        hex1_d = SegOff;
        hex2_d = SegOff;
      end
    endcase

    err_d   = fsm_err | occ_err;
    full_d  = (occ_d == OccMax);
    empty_d = (occ_d == '0);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      gate_q  <= 1'b0;
      green_q <= 1'b0;
      red_q   <= 1'b0;
      hex1_q  <= SegOff;
      hex2_q  <= SegOff;
      err_q   <= 1'b0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
    end else begin
      gate_q  <= gate_d;
      green_q <= green_d;
      red_q   <= red_d;
      hex1_q  <= hex1_d;
      hex2_q  <= hex2_d;
      err_q   <= err_d;
      full_q  <= full_d;
      empty_q <= empty_d;
    end
  end

  assign gate_open = gate_q;
  assign GREEN_LED = green_q;
  assign RED_LED   = red_q;
  assign HEX_1     = hex1_q;
  assign HEX_2     = hex2_q;
  assign occupancy = occ_q;
  assign lot_full  = full_q;
  assign lot_empty = empty_q;
  assign error     = err_q;

endmodule

// File: tb/tb_parking_exit_gate.sv
// Self-checking bench for parking_exit_gate: directed scenarios plus random
// stimulus checked against a behavioural model of the exit rules.
module tb_parking_exit_gate;

  localparam logic [3:0] FEE         = 4'b1010;
  localparam int         CAPACITY    = 16;
  localparam int         PAY_TIMEOUT = 8;
  localparam int         OPEN_CYCLES = 12;
  localparam int         MAX_TRIES   = 3;

  localparam int MIdle = 0, MWait = 1, MErr = 2, MOpen = 3, MClose = 4, MLock = 5;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       car_entered = 1'b0;
  logic       app = 1'b0;
  logic       clr = 1'b0;
  logic [3:0] code = 4'd0;
  logic       pv = 1'b0;
  logic       att = 1'b0;

  logic       gate_open, green, red, lot_full, lot_empty, err;
  logic [6:0] hex1, hex2;
  logic [4:0] occ;

  int checks = 0;
  int errors = 0;

  // Reference model state.
  int m_st, m_wait, m_open, m_tries, m_occ;
  bit m_red, m_green, m_err, m_prev_app;

  parking_exit_gate dut (
    .clk                 (clk),
    .reset               (reset),
    .car_entered         (car_entered),
    .sensor_exit_approach(app),
    .sensor_exit_clear   (clr),
    .pay_code            (code),
    .pay_valid           (pv),
    .attendant_clr       (att),
    .gate_open           (gate_open),
    .GREEN_LED           (green),
    .RED_LED             (red),
    .HEX_1               (hex1),
    .HEX_2               (hex2),
    .occupancy           (occ),
    .lot_full            (lot_full),
    .lot_empty           (lot_empty),
    .error               (err)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] exp_hex1(int st);
    case (st)
      MWait:   return 7'b1100111;
      MErr:    return 7'b1001111;
      MOpen:   return 7'b1011110;
      MClose:  return 7'b1001110;
      MLock:   return 7'b1001111;
      default: return 7'b0000000;
    endcase
  endfunction

  function automatic logic [6:0] exp_hex2(int st);
    case (st)
      MWait:   return 7'b1110111;
      MErr:    return 7'b0000101;
      MOpen:   return 7'b0011101;
      MClose:  return 7'b0001110;
      MLock:   return 7'b1001111;
      default: return 7'b0000000;
    endcase
  endfunction

  task automatic model_reset();
    m_st = MIdle; m_wait = 0; m_open = 0; m_tries = 0; m_occ = 0;
    m_red = 0; m_green = 0; m_err = 0; m_prev_app = 0;
  endtask

  // Applies one clock edge of the exit rules to the model.
  task automatic model_edge();
    int ns;
    bit e, dec;
    ns = m_st; e = 0; dec = 0;
    case (m_st)
      MIdle:
        if (app) begin
          if (m_occ == 0) e = !m_prev_app;
          else ns = MWait;
        end
      MWait:
        if (!app) ns = MIdle;
        else if (pv && code == FEE) ns = MOpen;
        else if (pv) begin ns = MErr; m_tries++; e = 1; end
        else if (m_wait == PAY_TIMEOUT - 1) begin ns = MErr; e = 1; end
      MErr:
        if (pv && code == FEE) ns = MOpen;
        else if (pv) begin
          m_tries++; e = 1;
          if (m_tries >= MAX_TRIES) ns = MLock;
        end else if (!app) ns = MIdle;
      MOpen:
        if (clr) begin ns = MClose; dec = 1; end
        else if (m_open == OPEN_CYCLES - 1) ns = MIdle;
      MClose: if (!clr) ns = MIdle;
      MLock:  if (att) ns = MIdle;
      default: ns = MIdle;
    endcase
    if (ns == MIdle || ns == MOpen) m_tries = 0;
    if (car_entered && !dec) begin
      if (m_occ == CAPACITY) e = 1;
      else m_occ++;
    end else if (dec && !car_entered) begin
      m_occ--;
    end
    m_wait = (ns == MWait && m_st == MWait) ? m_wait + 1 : 0;
    m_open = (ns == MOpen && m_st == MOpen) ? m_open + 1 : 0;
    if (ns == MErr) m_red = (m_st == MErr) ? !m_red : 1'b1;
    else m_red = (ns == MWait || ns == MLock);
    if (ns == MOpen) m_green = (m_st == MOpen) ? !m_green : 1'b1;
    else m_green = (ns == MClose);
    m_err = e;
    m_prev_app = app;
    m_st = ns;
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    car_entered = 0; app = 0; clr = 0; pv = 0; att = 0; code = 0;
    do_reset();
    checks++;
    if ({gate_open, green, red, hex1, hex2, occ, lot_full, lot_empty, err} !== 25'b10) begin
      errors++;
      $display("FAIL reset_state got %b want %b",
               {gate_open, green, red, hex1, hex2, occ, lot_full, lot_empty, err}, 25'b10);
    end
  endtask

  task automatic test_normal_exit();
    car_entered = 1; step(); step(); car_entered = 0;
    checks++;
    if (occ !== 5'd2) begin errors++; $display("FAIL entry_count got %0d want 2", occ); end
    app = 1; step();
    checks++;
    if ({hex1, hex2, red} !== {7'b1100111, 7'b1110111, 1'b1}) begin
      errors++; $display("FAIL wait_pay_display got %b %b red %b", hex1, hex2, red);
    end
    pv = 1; code = FEE; step(); pv = 0;
    checks++;
    if ({gate_open, green, hex1, hex2} !== {2'b11, 7'b1011110, 7'b0011101}) begin
      errors++; $display("FAIL open_after_pay gate %b green %b hex %b %b", gate_open, green,
                         hex1, hex2);
    end
    step();
    checks++;
    if ({gate_open, green} !== 2'b10) begin
      errors++; $display("FAIL green_blink gate %b green %b want 1 0", gate_open, green);
    end
    clr = 1; app = 0; step();
    checks++;
    if ({occ, gate_open, green, hex1, hex2} !== {5'd1, 2'b01, 7'b1001110, 7'b0001110}) begin
      errors++; $display("FAIL closing occ %0d gate %b green %b hex %b %b", occ, gate_open,
                         green, hex1, hex2);
    end
    step(); clr = 0; step();
    checks++;
    if ({occ, hex1, hex2, green, red} !== {5'd1, 16'd0}) begin
      errors++; $display("FAIL back_to_idle occ %0d hex %b %b leds %b%b", occ, hex1, hex2,
                         green, red);
    end
  endtask

  task automatic test_lockout();
    app = 1; step();
    for (int i = 1; i <= 3; i++) begin
      pv = 1; code = 4'b0011; step(); pv = 0;
      checks++;
      if (err !== 1'b1 || red !== 1'b1 || hex1 !== 7'b1001111) begin
        errors++; $display("FAIL wrong_code_%0d error %b red %b hex1 %b", i, err, red, hex1);
      end
      step();
      checks++;
      if (err !== 1'b0) begin errors++; $display("FAIL error_pulse_width_%0d got %b", i, err); end
    end
    checks++;
    if ({hex1, hex2, red} !== {7'b1001111, 7'b1001111, 1'b1}) begin
      errors++; $display("FAIL lock_display got %b %b red %b", hex1, hex2, red);
    end
    pv = 1; code = FEE; step(); pv = 0; step();
    checks++;
    if (gate_open !== 1'b0 || hex2 !== 7'b1001111) begin
      errors++; $display("FAIL lock_ignores_pay gate %b hex2 %b", gate_open, hex2);
    end
    app = 0; att = 1; step(); att = 0;
    checks++;
    if ({hex1, hex2, red} !== 15'd0) begin
      errors++; $display("FAIL attendant_clear got %b %b red %b", hex1, hex2, red);
    end
  endtask

  task automatic test_pay_timeout();
    bit r;
    app = 1; step();
    for (int i = 1; i < PAY_TIMEOUT; i++) begin
      step();
      checks++;
      if (hex1 !== 7'b1100111 || err !== 1'b0) begin
        errors++; $display("FAIL early_timeout cycle %0d hex1 %b error %b", i, hex1, err);
      end
    end
    step();
    checks++;
    if (hex1 !== 7'b1001111 || err !== 1'b1 || red !== 1'b1) begin
      errors++; $display("FAIL timeout_entry hex1 %b error %b red %b", hex1, err, red);
    end
    for (int i = 0; i < 2; i++) begin
      r = red; step();
      checks++;
      if (red !== !r || err !== 1'b0) begin
        errors++; $display("FAIL red_toggle got %b want %b error %b", red, !r, err);
      end
    end
    pv = 1; code = FEE; step(); pv = 0; app = 0;
    checks++;
    if (gate_open !== 1'b1) begin errors++; $display("FAIL pay_after_timeout gate %b", gate_open); end
    for (int i = 0; i < OPEN_CYCLES; i++) step();
  endtask

  task automatic test_gate_timeout();
    int cnt;
    app = 1; step();
    pv = 1; code = FEE; step(); pv = 0; app = 0;
    cnt = 0;
    while (gate_open === 1'b1 && cnt < 40) begin
      cnt++; step();
    end
    checks++;
    if (cnt !== OPEN_CYCLES || occ !== 5'd1 || hex1 !== 7'd0) begin
      errors++; $display("FAIL gate_timeout open %0d cycles want %0d occ %0d hex1 %b", cnt,
                         OPEN_CYCLES, occ, hex1);
    end
  endtask

  task automatic test_occupancy();
    do_reset();
    app = 1; step();
    checks++;
    if (err !== 1'b1 || hex1 !== 7'd0) begin
      errors++; $display("FAIL empty_approach error %b hex1 %b want 1 0", err, hex1);
    end
    step();
    checks++;
    if (err !== 1'b0 || hex1 !== 7'd0) begin
      errors++; $display("FAIL empty_approach_hold error %b hex1 %b want 0 0", err, hex1);
    end
    app = 0; step();
    for (int i = 1; i <= CAPACITY + 1; i++) begin
      car_entered = 1; step();
      checks++;
      if (err !== (i == CAPACITY + 1) || occ !== 5'((i > CAPACITY) ? CAPACITY : i)) begin
        errors++; $display("FAIL fill_%0d occ %0d error %b", i, occ, err);
      end
    end
    car_entered = 0;
    checks++;
    if (lot_full !== 1'b1 || lot_empty !== 1'b0) begin
      errors++; $display("FAIL lot_full got %b want 1", lot_full);
    end
    app = 1; step();
    pv = 1; code = FEE; step(); pv = 0;
    clr = 1; car_entered = 1; step(); car_entered = 0;
    checks++;
    if (occ !== 5'd16 || err !== 1'b0 || hex1 !== 7'b1001110) begin
      errors++; $display("FAIL coincident_inc_dec occ %0d error %b hex1 %b", occ, err, hex1);
    end
    clr = 0; app = 0; step();
  endtask

  task automatic test_mid_reset();
    app = 1; step();
    pv = 1; code = FEE; step(); pv = 0; app = 0;
    checks++;
    if (gate_open !== 1'b1) begin errors++; $display("FAIL reach_open gate %b", gate_open); end
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({gate_open, green, red, hex1, hex2, occ, lot_full, lot_empty, err} !== 25'b10) begin
      errors++; $display("FAIL async_reset got %b",
                         {gate_open, green, red, hex1, hex2, occ, lot_full, lot_empty, err});
    end
    model_reset();
    @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic test_random();
    logic [24:0] got, want;
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      car_entered = ($urandom_range(3) == 0);
      if ($urandom_range(7) == 0) app = !app;
      pv   = ($urandom_range(3) == 0);
      code = ($urandom_range(1) == 0) ? FEE : 4'($urandom);
      clr  = ($urandom_range(3) == 0);
      att  = ($urandom_range(15) == 0);
      step();
      got  = {gate_open, green, red, hex1, hex2, occ, lot_full, lot_empty, err};
      want = {(m_st == MOpen), m_green, m_red, exp_hex1(m_st), exp_hex2(m_st), 5'(m_occ),
              (m_occ == CAPACITY), (m_occ == 0), m_err};
      checks++;
      if (got !== want) begin
        errors++; $display("FAIL random cycle %0d got %b want %b", i, got, want);
      end
    end
    car_entered = 0; app = 0; pv = 0; clr = 0; att = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_normal_exit();
    test_lockout();
    test_pay_timeout();
    test_gate_timeout();
    test_occupancy();
    test_mid_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/parking_exit_gate.md
# parking_exit_gate

Exit-side controller for the car park: the counterpart of the entrance gate controller. It tracks lot occupancy from entry pulses and verified exits. It validates the driver's exit payment code, opens the exit barrier for a bounded time, and drives status LEDs and two 7-segment digits. It sits beside the entrance controller, which supplies the `car_entered` pulse.

## Interface
- `FEE_CODE`, 4'b1010 — exit payment code accepted on `pay_code`.
- `CAPACITY`, 16 — maximum occupancy; `CNT_W` must hold it.
- `CNT_W`, 5 — occupancy counter width.
- `PAY_TIMEOUT`, 8 — cycles allowed in WAIT_PAY before a timeout error.
- `OPEN_CYCLES`, 12 — maximum cycles the barrier stays open waiting for the car to clear.
- `MAX_TRIES`, 3 — wrong codes allowed before lockout.

Ports (clock and reset first):
- `clk` — in, 1 — clock, all logic on the rising edge.
- `reset` — in, 1 — reset, asynchronous, active-high.
- `car_entered` — in, 1 — one-cycle pulse from the entrance side; a car has entered.
- `sensor_exit_approach` — in, 1 — car present at the exit barrier.
- `sensor_exit_clear` — in, 1 — car has passed the barrier line.
- `pay_code` — in, 4 — payment code, sampled only when `pay_valid`=1.
- `pay_valid` — in, 1 — one-cycle strobe qualifying `pay_code`.
- `attendant_clr` — in, 1 — clears LOCK state.
- `gate_open` — out, 1 — barrier open command.
- `GREEN_LED` — out, 1 — green status LED.
- `RED_LED` — out, 1 — red status LED.
- `HEX_1` — out, 7 — left digit, segments a..g MSB→LSB, 1=lit.
- `HEX_2` — out, 7 — right digit, same encoding as `HEX_1`.
- `occupancy` — out, CNT_W — current car count.
- `lot_full` — out, 1 — `occupancy`==CAPACITY.
- `lot_empty` — out, 1 — `occupancy`==0.
- `error` — out, 1 — one-cycle pulse on a rejected event: phantom exit, wrong code, timeout, or increment at full.

## Operation
States: IDLE, WAIT_PAY, PAY_ERR, OPEN, CLOSING, LOCK.
- IDLE:
  - If `sensor_exit_approach`=1 and !`lot_empty`, go to WAIT_PAY.
  - If `sensor_exit_approach`=1 and `lot_empty`, stay in IDLE and pulse `error` once, on the rising edge of approach.
- WAIT_PAY: the wait counter starts at 0 on entry and increments each cycle. Priority of transitions, highest first:
  1. `sensor_exit_approach`=0 → IDLE.
  2. `pay_valid` with a correct code → OPEN.
  3. `pay_valid` with a wrong code → PAY_ERR; tries+1; `error` pulse.
  4. Wait counter reaches PAY_TIMEOUT-1 → PAY_ERR; `error` pulse; tries unchanged.
- PAY_ERR:
  - Correct code → OPEN.
  - Wrong code → tries+1 and `error` pulse. When tries reaches MAX_TRIES → LOCK.
  - `sensor_exit_approach`=0 → IDLE.
- OPEN: `gate_open`=1. The open timer starts at 0 on entry.
  - `sensor_exit_clear`=1 → CLOSING, and `occupancy` is decremented in that same transition.
  - Timer reaches OPEN_CYCLES-1 with no clear → IDLE, no decrement.
- CLOSING: `gate_open`=0. Go to IDLE when `sensor_exit_clear`=0. Approach in this state is ignored; a following car must pay separately.
- LOCK: only `attendant_clr`=1 exits, to IDLE. Pay strobes are ignored.
- The tries counter clears on entry to OPEN and on entry to IDLE.
- Occupancy:
  - `car_entered` alone → +1. At CAPACITY the increment is dropped and `error` pulses.
  - Exit decrement alone → -1. Decrement never occurs at 0, because the IDLE guard prevents it.
  - Simultaneous increment and decrement → unchanged.
- Display and LEDs per state, as HEX_1/HEX_2, then LEDs:
  - IDLE: off/off; LEDs 0/0.
  - WAIT_PAY: "P" 1100111 / "A" 1110111; red=1.
  - PAY_ERR: "E" 1001111 / "r" 0000101; red blinks.
  - OPEN: "G" 1011110 / "o" 0011101; green blinks.
  - CLOSING: "C" 1001110 / "L" 0001110; green=1.
  - LOCK: "E" / "E"; red=1.
- Blinking LEDs are set to 1 on state entry and toggle every cycle while in the state.

## Timing
- All outputs are registered and computed from next-state. Outputs change on the same clock edge the state changes, so they are valid the cycle the state is entered.
- Reset (async) sets state to IDLE and clears all counters and the tries count. All outputs go to 0, except `lot_empty`=1.
- Reset asserted mid-OPEN closes the gate immediately (asynchronously) and does not decrement `occupancy`.
- Latencies, counting from the edge at which the input is sampled:
  - Correct code in WAIT_PAY → `gate_open`=1 after the next edge (1 cycle).
  - `car_entered` → `occupancy` updates after 1 edge.
  - `lot_full`/`lot_empty` track `occupancy` in the same cycle.
- Timeout: the WAIT_PAY → PAY_ERR transition happens exactly PAY_TIMEOUT cycles after entry with no strobe.
- The gate is open for at most OPEN_CYCLES cycles.

## Test plan
- Normal exit:
  - Stimulus: 2× `car_entered`, approach=1, `pay_code`=1010 with strobe, then clear=1 for 2 cycles, then 0.
  - Required: occupancy 2→1; `gate_open` high from the cycle after the strobe until clear; HEX "Go" then "CL" then off.
- Wrong code and lockout:
  - Stimulus: occupancy 1, approach held, three strobes of 0011.
  - Required: three `error` pulses; after the 3rd, state LOCK with HEX "EE" and red=1; a correct code is ignored; `attendant_clr` returns to IDLE.
- Payment timeout:
  - Stimulus: approach held with no strobe for 8 cycles, then a correct code.
  - Required: PAY_ERR exactly 8 cycles after WAIT_PAY entry with one `error` pulse; red toggles each cycle; the correct code then opens the gate.
- Gate timeout:
  - Stimulus: correct code, clear never asserts.
  - Required: `gate_open` high for exactly 12 cycles, then IDLE; occupancy unchanged.
- Occupancy boundaries:
  - Empty lot + approach → `error` pulse, no WAIT_PAY.
  - 17 entry pulses → occupancy saturates at 16, `lot_full`=1, one `error` pulse on the 17th.
  - `car_entered` coincident with the exit decrement → occupancy unchanged.
- Mid-operation reset:
  - Stimulus: assert reset while in OPEN.
  - Required: `gate_open`, LEDs and HEX go to 0 immediately, and `occupancy` returns to 0.
